// File: rtl/lsu_rmw.sv
// Byte/half/word load-store unit over a word-wide RAM; sub-word stores are read-modify-write.
// Optional macro LSU_MISALIGN_TRAP_EN turns misaligned or reserved-size accesses into error responses.
module lsu_rmw (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic        req_we_i,
   input  logic [31:0] req_addr_i,
   input  logic [31:0] req_wdata_i,
   input  logic [1:0]  req_size_i,
   input  logic        req_unsigned_i,
   output logic        rsp_valid_o,
   output logic [31:0] rsp_rdata_o,
   output logic        rsp_err_o,
   output logic        ram_wr_en_o,
   output logic [31:0] ram_addr_o,
   output logic [31:0] ram_data_o,
   input  logic [31:0] ram_data_i,
   output logic [1:0]  fsm_state
);
   // Handshake: a request transfers on a rising edge with req_valid_i && req_ready_o;
   // the response is a single rsp_valid_o pulse with no backpressure.
   typedef enum logic [1:0] {IDLE = 2'd0, RD = 2'd1, WR = 2'd2, RSP = 2'd3} state_t;

   state_t      state;
   logic        we_q;
   logic        uns_q;
   logic [1:0]  size_q;
   logic [1:0]  off_q;
   logic [15:0] wdata_q;
   logic        trap;

`ifdef LSU_MISALIGN_TRAP_EN
   assign trap = (req_size_i == 2'b11) ||
                 (req_size_i == 2'b10 && req_addr_i[1:0] != 2'b00) ||
                 (req_size_i == 2'b01 && req_addr_i[0]);
`else
   assign trap = 1'b0;
`endif

   assign req_ready_o = (state == IDLE);
   assign fsm_state   = state;

   function automatic logic [31:0] merge(input logic [31:0] word, input logic [15:0] wdata,
                                         input logic [1:0] size, input logic [1:0] off);
      logic [31:0] m;
      m = word;
      if (size == 2'b00) begin
         case (off)
            2'd0:    m[7:0]   = wdata[7:0];
            2'd1:    m[15:8]  = wdata[7:0];
            2'd2:    m[23:16] = wdata[7:0];
            default: m[31:24] = wdata[7:0];
         endcase
      end else if (size == 2'b01) begin
         if (off[1]) m[31:16] = wdata;
         else        m[15:0]  = wdata;
      end
      return m;
   endfunction

   function automatic logic [31:0] extend(input logic [31:0] word, input logic [1:0] size,
                                          input logic uns, input logic [1:0] off);
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] r;
      case (off)
         2'd0:    b = word[7:0];
         2'd1:    b = word[15:8];
         2'd2:    b = word[23:16];
         default: b = word[31:24];
      endcase
      h = off[1] ? word[31:16] : word[15:0];
      if (size == 2'b00)      r = uns ? {24'h0, b} : {{24{b[7]}}, b};
      else if (size == 2'b01) r = uns ? {16'h0, h} : {{16{h[15]}}, h};
      else                    r = word;
      return r;
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         we_q        <= 1'b0;
         uns_q       <= 1'b0;
         size_q      <= 2'b00;
         off_q       <= 2'b00;
         wdata_q     <= 16'h0;
         rsp_valid_o <= 1'b0;
         rsp_rdata_o <= 32'h0;
         rsp_err_o   <= 1'b0;
         ram_wr_en_o <= 1'b0;
         ram_addr_o  <= 32'h0;
         ram_data_o  <= 32'h0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid_i) begin
                  we_q    <= req_we_i;
                  uns_q   <= req_unsigned_i;
                  size_q  <= req_size_i;
                  off_q   <= req_addr_i[1:0];
                  wdata_q <= req_wdata_i[15:0];
                  if (trap) begin
                     state       <= RSP;
                     rsp_valid_o <= 1'b1;
                     rsp_err_o   <= 1'b1;
                     rsp_rdata_o <= 32'h0;
                  end else begin
                     ram_addr_o <= {req_addr_i[31:2], 2'b00};
                     // Full-word stores need no read; reserved size behaves as word here.
                     if (req_we_i && req_size_i[1]) begin
                        state       <= WR;
                        ram_wr_en_o <= 1'b1;
                        ram_data_o  <= req_wdata_i;
                     end else begin
                        state <= RD;
                     end
                  end
               end
            end
            RD: begin
               if (we_q) begin
                  ram_data_o  <= merge(ram_data_i, wdata_q, size_q, off_q);
                  ram_wr_en_o <= 1'b1;
                  state       <= WR;
               end else begin
                  rsp_valid_o <= 1'b1;
                  rsp_rdata_o <= extend(ram_data_i, size_q, uns_q, off_q);
                  state       <= RSP;
               end
            end
            WR: begin
               ram_wr_en_o <= 1'b0;
               rsp_valid_o <= 1'b1;
               rsp_rdata_o <= 32'h0;
               state       <= RSP;
            end
            RSP: begin
               rsp_valid_o <= 1'b0;
               rsp_rdata_o <= 32'h0;
               rsp_err_o   <= 1'b0;
               state       <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_lsu_rmw.sv
// Bench for lsu_rmw: word RAM model, reference memory, response/write scoreboards, reset-abort case.
module tb_lsu_rmw;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid_i = 1'b0;
   logic        req_ready_o;
   logic        req_we_i = 1'b0;
   logic [31:0] req_addr_i = 32'h0;
   logic [31:0] req_wdata_i = 32'h0;
   logic [1:0]  req_size_i = 2'b00;
   logic        req_unsigned_i = 1'b0;
   logic        rsp_valid_o;
   logic [31:0] rsp_rdata_o;
   logic        rsp_err_o;
   logic        ram_wr_en_o;
   logic [31:0] ram_addr_o;
   logic [31:0] ram_data_o;
   logic [31:0] ram_data_i;
   logic [1:0]  fsm_state;

   logic [31:0] mem [0:63];
   logic [31:0] ref_mem [0:63];
   logic [36:0] exp_q[$];   // {latency[3:0], err, rdata}
   logic [67:0] wr_q[$];    // {latency[3:0], addr, data}
   int          checks = 0;
   int          failures = 0;
   int          cyc = 0;
   int          acc_cyc = 0;
   logic [36:0] e;
   logic [67:0] w;

   lsu_rmw dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
      .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i), .req_size_i(req_size_i),
      .req_unsigned_i(req_unsigned_i),
      .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
      .ram_wr_en_o(ram_wr_en_o), .ram_addr_o(ram_addr_o), .ram_data_o(ram_data_o),
      .ram_data_i(ram_data_i), .fsm_state(fsm_state)
   );

   always #5 clk = ~clk;

   assign ram_data_i = mem[ram_addr_o[7:2]];
   always @(posedge clk) if (ram_wr_en_o) mem[ram_addr_o[7:2]] <= ram_data_o;

   always @(posedge clk) begin
      cyc = cyc + 1;
      if (req_valid_i && req_ready_o) acc_cyc = cyc;
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] model_load(input logic [31:0] wd, input logic [1:0] sz,
                                              input logic uns, input logic [1:0] a);
      logic [31:0] s;
      if (sz == 2'b00) begin
         s = wd >> (8 * int'(a));
         return uns ? (s & 32'hFF) : 32'($signed(s[7:0]));
      end else if (sz == 2'b01) begin
         s = wd >> (16 * int'(a[1]));
         return uns ? (s & 32'hFFFF) : 32'($signed(s[15:0]));
      end
      return wd;
   endfunction

   function automatic logic [31:0] model_store(input logic [31:0] old, input logic [31:0] wd,
                                               input logic [1:0] sz, input logic [1:0] a);
      logic [31:0] mask;
      logic [31:0] sh;
      if (sz[1]) return wd;
      if (sz == 2'b00) begin
         mask = 32'hFF << (8 * int'(a));
         sh   = (wd & 32'hFF) << (8 * int'(a));
      end else begin
         mask = 32'hFFFF << (16 * int'(a[1]));
         sh   = (wd & 32'hFFFF) << (16 * int'(a[1]));
      end
      return (old & ~mask) | (sh & mask);
   endfunction

   always @(negedge clk) begin
      if (rsp_valid_o) begin
         if (exp_q.size() == 0) check("rsp_unexpected", 64'd1, 64'd0);
         else begin
            e = exp_q.pop_front();
            check("rsp_rdata", 64'(rsp_rdata_o), 64'(e[31:0]));
            check("rsp_err", 64'(rsp_err_o), 64'(e[32]));
            check("rsp_latency", 64'(cyc - acc_cyc + 1), 64'(e[36:33]));
         end
      end else begin
         check("rsp_idle_zero", 64'({rsp_err_o, rsp_rdata_o}), 64'd0);
      end
      if (ram_wr_en_o) begin
         if (wr_q.size() == 0) check("wr_unexpected", 64'd1, 64'd0);
         else begin
            w = wr_q.pop_front();
            check("wr_addr", 64'(ram_addr_o), 64'(w[63:32]));
            check("wr_data", 64'(ram_data_o), 64'(w[31:0]));
            check("wr_latency", 64'(cyc - acc_cyc + 1), 64'(w[67:64]));
         end
      end
   end

   task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [1:0] sz, input logic uns);
      logic [31:0] old;
      logic [31:0] nw;
      logic        trap;
      old  = ref_mem[addr[7:2]];
      trap = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
      trap = (sz == 2'b11) || (sz == 2'b10 && addr[1:0] != 2'b00) || (sz == 2'b01 && addr[0]);
`endif
      if (trap) begin
         exp_q.push_back({4'd1, 1'b1, 32'h0});
      end else if (we) begin
         nw = model_store(old, wd, sz, addr[1:0]);
         ref_mem[addr[7:2]] = nw;
         if (sz[1]) begin
            wr_q.push_back({4'd1, addr[31:2], 2'b00, nw});
            exp_q.push_back({4'd2, 1'b0, 32'h0});
         end else begin
            wr_q.push_back({4'd2, addr[31:2], 2'b00, nw});
            exp_q.push_back({4'd3, 1'b0, 32'h0});
         end
      end else begin
         exp_q.push_back({4'd2, 1'b0, model_load(old, sz, uns, addr[1:0])});
      end
      @(negedge clk);
      for (int i = 0; i < 20 && !req_ready_o; i++) @(negedge clk);
      if (!req_ready_o) check("ready_timeout", 64'd0, 64'd1);
      req_valid_i    = 1'b1;
      req_we_i       = we;
      req_addr_i     = addr;
      req_wdata_i    = wd;
      req_size_i     = sz;
      req_unsigned_i = uns;
      @(posedge clk);
      #1;
      // Scramble the request fields while busy; the DUT must work from its captured copy.
      req_valid_i    = 1'b0;
      req_we_i       = 1'($urandom_range(0, 1));
      req_addr_i     = $urandom();
      req_wdata_i    = $urandom();
      req_size_i     = 2'($urandom_range(0, 3));
      req_unsigned_i = 1'($urandom_range(0, 1));
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((exp_q.size() != 0 || wr_q.size() != 0) && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (exp_q.size() != 0 || wr_q.size() != 0) begin
         check("drain_timeout", 64'(exp_q.size() + wr_q.size()), 64'd0);
         exp_q.delete();
         wr_q.delete();
      end
   endtask

   initial begin
      logic [31:0] saved;
      for (int i = 0; i < 64; i++) mem[i] = $urandom();
      mem[4] = 32'h8899AABB;
      mem[8] = 32'h0;
      for (int i = 0; i < 64; i++) ref_mem[i] = mem[i];

      #12;
      check("reset_ready", 64'(req_ready_o), 64'd1);
      check("reset_state", 64'(fsm_state), 64'd0);
      check("reset_rsp_valid", 64'(rsp_valid_o), 64'd0);
      check("reset_wr_en", 64'(ram_wr_en_o), 64'd0);
      check("reset_ram_addr", 64'(ram_addr_o), 64'd0);
      check("reset_ram_data", 64'(ram_data_o), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;

      issue(1'b0, 32'h11, 32'h0, 2'b00, 1'b0); drain();
      issue(1'b0, 32'h12, 32'h0, 2'b01, 1'b1); drain();
      issue(1'b1, 32'h13, 32'h5C, 2'b00, 1'b0); drain();
      check("mem_after_byte_store", 64'(mem[4]), 64'h5C99AABB);
      issue(1'b1, 32'h20, 32'h12345678, 2'b10, 1'b0); drain();
      check("mem_after_word_store", 64'(mem[8]), 64'h12345678);
      issue(1'b0, 32'h22, 32'h0, 2'b10, 1'b0); drain();
      issue(1'b0, 32'h13, 32'h0, 2'b00, 1'b1); drain();
      issue(1'b0, 32'h12, 32'h0, 2'b01, 1'b0); drain();
      issue(1'b1, 32'h16, 32'hBEEF, 2'b01, 1'b0); drain();

      // Reset while the byte store sits in RD: no write, no response.
      saved = ref_mem[12];
      issue(1'b1, 32'h31, 32'hA5, 2'b00, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      check("abort_ready", 64'(req_ready_o), 64'd1);
      check("abort_state", 64'(fsm_state), 64'd0);
      check("abort_wr_en", 64'(ram_wr_en_o), 64'd0);
      check("abort_rsp_valid", 64'(rsp_valid_o), 64'd0);
      exp_q.delete();
      wr_q.delete();
      ref_mem[12] = saved;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      check("abort_mem", 64'(mem[12]), 64'(saved));
      check("abort_ready_after", 64'(req_ready_o), 64'd1);

      for (int k = 0; k < 60; k++) begin
         issue(1'($urandom_range(0, 1)), 32'($urandom_range(0, 255)), $urandom(),
               2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
         drain();
      end
      for (int i = 0; i < 64; i++) check("final_mem", 64'(mem[i]), 64'(ref_mem[i]));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/lsu_rmw.md
LSU_RMW -- requirements
Module: lsu_rmw

Interface
REQ-001 SHALL have no parameters; widths come from the core defines (32-bit address and data).
REQ-002 clk  input  1  system clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req_valid_i  input  1  core access request.
REQ-005 req_ready_o  output  1  request accepted when req_valid_i && req_ready_o at a rising edge.
REQ-006 req_we_i  input  1  1 = store, 0 = load.
REQ-007 req_addr_i  input  32  byte address.
REQ-008 req_wdata_i  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-009 req_size_i  input  2  00 byte, 01 half, 10 word, 11 reserved.
REQ-010 req_unsigned_i  input  1  1 = zero-extend load, 0 = sign-extend.
REQ-011 rsp_valid_o  output  1  one-cycle completion pulse.
REQ-012 rsp_rdata_o  output  32  extended load data; 0 for stores.
REQ-013 rsp_err_o  output  1  access error (see Configuration).
REQ-014 ram_wr_en_o  output  1  word RAM write enable.
REQ-015 ram_addr_o  output  32  word RAM address, always {addr[31:2],2'b00}.
REQ-016 ram_data_o  output  32  word RAM write data.
REQ-017 ram_data_i  input  32  word RAM read data, combinational from ram_addr_o.

Function
REQ-018 FSM states IDLE, RD, WR, RSP; req_ready_o = 1 only in IDLE.
REQ-019 On acceptance, addr, wdata, size, we and unsigned SHALL be registered; inputs are ignored until return to IDLE.
REQ-020 Load: IDLE -> RD -> RSP -> IDLE; rsp_valid_o high in the 2nd cycle after the acceptance edge.
REQ-021 Byte/half store: IDLE -> RD -> WR -> RSP -> IDLE; rsp_valid_o high in the 3rd cycle after acceptance.
REQ-022 Word store: IDLE -> WR -> RSP -> IDLE; no read; rsp_valid_o high in the 2nd cycle after acceptance.
REQ-023 In RD, ram_data_i SHALL be captured into an internal word register at the closing edge.
REQ-024 In WR, ram_wr_en_o = 1 for exactly one cycle. ram_data_o carries the captured word with only the target lane(s) replaced (byte lane addr[1:0]; half lane addr[1]) or, for a word store, req_wdata_i.
REQ-025 Load data: select lane as in REQ-024, then sign- or zero-extend per req_unsigned_i; word loads are unextended.
REQ-026 rsp_valid_o SHALL be high for exactly one cycle per accepted request; there is no response backpressure.
REQ-027 rsp_rdata_o and rsp_err_o SHALL be valid only while rsp_valid_o = 1, and 0 otherwise.
REQ-028 ram_wr_en_o SHALL be 0 in every state except WR; ram_addr_o holds its last value outside RD/WR.
REQ-029 A new request MAY be accepted in the IDLE cycle immediately after RSP; back-to-back throughput is one request per 3–4 cycles.

Reset
REQ-030 Asynchronous assertion of rst_n SHALL force IDLE, and force rsp_valid_o, rsp_rdata_o, rsp_err_o, ram_wr_en_o, ram_addr_o and ram_data_o to 0; req_ready_o reads 1.
REQ-031 Reset asserted during RD or WR before the write edge SHALL abort the access; no RAM write and no response occur.

Configuration
REQ-032 Macro LSU_MISALIGN_TRAP_EN defined: half with addr[0]=1, word with addr[1:0]!=0, or size 11 SHALL go IDLE -> RSP without RAM access, with rsp_err_o=1 and rsp_rdata_o=0.
REQ-033 Macro undefined: rsp_err_o is tied 0, size 11 is treated as word, and the ignored low address bits are dropped (word uses addr[31:2]; half uses addr[1]).

Verification
REQ-034 RAM word@0x10=0x8899AABB, load byte signed addr 0x11 -> rsp_valid_o 2 cycles after accept, rsp_rdata_o=0xFFFFFFAA.
REQ-035 Same word, load half unsigned addr 0x12 -> rsp_rdata_o=0x00008899.
REQ-036 Store byte 0x5C to addr 0x13 -> exactly one ram_wr_en_o pulse with ram_data_o=0x5C99AABB; rsp_valid_o 3 cycles after accept.
REQ-037 Store word 0x12345678 to 0x20 -> no RD state, write at 0x20, rsp_valid_o 2 cycles after accept, rsp_rdata_o=0.
REQ-038 Load word addr 0x22: with LSU_MISALIGN_TRAP_EN -> rsp_err_o=1 one cycle after accept, no RAM access; without it -> data of word 0x20, rsp_err_o=0.
REQ-039 Assert rst_n low during RD of a byte store -> no ram_wr_en_o pulse, no rsp_valid_o, req_ready_o=1 after release.
